// File: rtl/ram_writer_pkg.sv
// Shared types and constants for the RAM test-pattern writer.
//   state_e    : sequencer states (IDLE, SETUP, WRITE, GAP, ADVANCE)
//   MODE_*     : pattern mode encodings on i_mode (3 aliases ramp)
package ram_writer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    WRITE   = 3'd2,
    GAP     = 3'd3,
    ADVANCE = 3'd4
  } state_e;

  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;

  // Phase counter width able to hold (max_cycles - 1)
  function automatic int unsigned phase_width(input int unsigned max_cyc);
    return $clog2(max_cyc) + 1;
  endfunction

endpackage

// File: rtl/ram_pattern_writer_if.sv
// Control + RAM write bus of the pattern writer.
//   master : the writer (samples i_* control, drives o_* RAM/status)
//   slave  : the sequencer/RAM side
interface ram_pattern_writer_if #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 16,
  parameter int unsigned ADDR_W = 14
);
  localparam int unsigned DATA_W = LANES * LANE_W;
  localparam int unsigned BE_W   = DATA_W / 8;

  logic                i_start;
  logic                i_stop;
  logic                i_continuous;
  logic [1:0]          i_mode;
  logic [LANE_W-1:0]   i_seed;
  logic [ADDR_W-1:0]   i_base_addr;
  logic [ADDR_W:0]     i_count;
  logic [DATA_W-1:0]   o_data;
  logic [ADDR_W-1:0]   o_address;
  logic [BE_W-1:0]     o_byteen;
  logic                o_wbit;
  logic                o_busy;
  logic                o_done;

  modport master (
    input  i_start, i_stop, i_continuous, i_mode, i_seed, i_base_addr, i_count,
    output o_data, o_address, o_byteen, o_wbit, o_busy, o_done
  );

  modport slave (
    output i_start, i_stop, i_continuous, i_mode, i_seed, i_base_addr, i_count,
    input  o_data, o_address, o_byteen, o_wbit, o_busy, o_done
  );

endinterface

// File: rtl/ram_pattern_gen.sv
// Lane pattern generator: LANES registered lanes, loaded from a seed and
// stepped once per written word according to the latched mode.
//   i_clk, i_rst_n : clock, async active-low reset
//   load           : capture seed/mode (word 0)
//   step           : advance to the next word
//   mode, seed     : pattern selection and lane-0 seed (used on load)
//   word           : packed lanes, lane 0 in the MSBs (flop outputs)
module ram_pattern_gen
  import ram_writer_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    load,
  input  logic                    step,
  input  logic [1:0]              mode,
  input  logic [LANE_W-1:0]       seed,
  output logic [LANES*LANE_W-1:0] word
);

  logic [1:0]        mode_q;
  logic [LANE_W-1:0] lane_q [LANES];

  // Lane registers; mode is captured with the seed so stepping follows the run
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q <= MODE_RAMP;
      for (int k = 0; k < LANES; k++) lane_q[k] <= '0;
    end else if (load) begin
      mode_q <= mode;
      for (int k = 0; k < LANES; k++) begin
        if (mode == MODE_CONST || mode == MODE_CHECK) lane_q[k] <= seed;
        else                                          lane_q[k] <= seed + LANE_W'(k);
      end
    end else if (step) begin
      for (int k = 0; k < LANES; k++) begin
        case (mode_q)
          MODE_CONST: lane_q[k] <= lane_q[k];
          MODE_CHECK: lane_q[k] <= ~lane_q[k];
          default:    lane_q[k] <= lane_q[k] + LANE_W'(LANES);
        endcase
      end
    end
  end

  // Pack lanes, lane 0 at the top
  always_comb begin
    word = '0;
    for (int k = 0; k < LANES; k++) begin
      word[(LANES-1-k)*LANE_W +: LANE_W] = lane_q[k];
    end
  end

endmodule

// File: rtl/ram_pattern_writer.sv
// RAM test-pattern writer: walks an address window writing one pattern word
// per address with a SETUP / WRITE (strobe) / GAP / ADVANCE sequence.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (master)   : i_start/i_stop/i_continuous/i_mode/i_seed/i_base_addr/i_count
//                    control in; o_data/o_address/o_byteen/o_wbit RAM write bus
//                    and o_busy/o_done status out (all registered)
module ram_pattern_writer
  import ram_writer_pkg::*;
#(
  parameter int unsigned LANES     = 4,
  parameter int unsigned LANE_W    = 16,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned DEPTH     = 2048,
  parameter int unsigned SETUP_CYC = 5,
  parameter int unsigned HOLD_CYC  = 5,
  parameter int unsigned GAP_CYC   = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  ram_pattern_writer_if.master bus
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned BE_W   = LANES * LANE_W / 8;
  localparam int unsigned PH_MAX = (SETUP_CYC > HOLD_CYC)
                                   ? ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC)
                                   : ((HOLD_CYC  > GAP_CYC) ? HOLD_CYC  : GAP_CYC);
  localparam int unsigned PH_W   = phase_width(PH_MAX);

  state_e            state_q, state_n;
  logic [PH_W-1:0]   phase_q;
  logic [CNT_W-1:0]  idx_q;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] base_q;
  logic              cont_q;

  logic [BE_W-1:0]   byteen_q;
  logic              wbit_q;
  logic              busy_q;
  logic              done_q;

  logic              start_c;
  logic              adv_c;
  logic              done_c;
  logic              rewind_c;
  logic              phase_end_c;
  logic [PH_W-1:0]   phase_lim_c;
  logic [CNT_W-1:0]  idx_inc_c;
  logic [ADDR_W-1:0] addr_inc_c;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_n;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_n     = state_q;
    start_c     = 1'b0;
    adv_c       = 1'b0;
    done_c      = 1'b0;
    rewind_c    = 1'b0;
    phase_lim_c = '0;
    idx_inc_c   = idx_q + CNT_W'(1);
    addr_inc_c  = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);

    case (state_q)
      SETUP:   phase_lim_c = PH_W'(SETUP_CYC - 1);
      WRITE:   phase_lim_c = PH_W'(HOLD_CYC - 1);
      GAP:     phase_lim_c = PH_W'(GAP_CYC - 1);
      default: phase_lim_c = '0;
    endcase
    phase_end_c = (phase_q == phase_lim_c);

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          start_c = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP:   if (phase_end_c) state_n = WRITE;
      WRITE:   if (phase_end_c) state_n = GAP;
      GAP:     if (phase_end_c) state_n = ADVANCE;
      ADVANCE: begin
        adv_c = 1'b1;
        if (bus.i_stop) begin
          done_c  = 1'b1;
          state_n = IDLE;
        end else if (idx_inc_c == count_q) begin
          done_c = 1'b1;
          if (cont_q) begin
            rewind_c = 1'b1;
            state_n  = SETUP;
          end else begin
            state_n = IDLE;
          end
        end else begin
          state_n = SETUP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Phase, window counters, run configuration and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_q  <= '0;
      idx_q    <= '0;
      count_q  <= '0;
      addr_q   <= '0;
      base_q   <= '0;
      cont_q   <= 1'b0;
      byteen_q <= '0;
      wbit_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // Phase restarts on every state change
      phase_q <= (state_n == state_q && state_q != IDLE) ? phase_q + PH_W'(1) : '0;

      if (start_c) begin
        base_q  <= bus.i_base_addr;
        count_q <= (bus.i_count == '0) ? CNT_W'(DEPTH) : bus.i_count;
        cont_q  <= bus.i_continuous;
        addr_q  <= bus.i_base_addr;
        idx_q   <= '0;
      end else if (adv_c) begin
        if (rewind_c) begin
          addr_q <= base_q;
          idx_q  <= '0;
        end else begin
          addr_q <= addr_inc_c;
          idx_q  <= idx_inc_c;
        end
      end

      byteen_q <= (state_n != IDLE) ? '1 : '0;
      wbit_q   <= (state_n == WRITE);
      busy_q   <= (state_n != IDLE);
      done_q   <= done_c;
    end
  end

  ram_pattern_gen #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .load    (start_c),
    .step    (adv_c),
    .mode    (bus.i_mode),
    .seed    (bus.i_seed),
    .word    (bus.o_data)
  );

  assign bus.o_address = addr_q;
  assign bus.o_byteen  = byteen_q;
  assign bus.o_wbit    = wbit_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;

endmodule

// File: tb/tb_ram_pattern_writer.sv
// Self-checking bench for ram_pattern_writer: directed table, hand-written
// corner sequences and randomized runs against a formula-level model.
module tb_ram_pattern_writer;

  localparam int LANES  = 4;
  localparam int LANE_W = 16;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 2048;
  localparam int SETUP  = 5;
  localparam int HOLD   = 5;
  localparam int GAPC   = 5;
  localparam int PERIOD = SETUP + HOLD + GAPC + 1;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  ram_pattern_writer_if #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) bus ();

  ram_pattern_writer #(
    .LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .GAP_CYC(GAPC)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] seed;
    int          base;
    int          count;
    logic [15:0] w1_l0;
    logic [15:0] w1_l3;
    int          last_addr;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  logic [ADDR_W-1:0] cap_addr[$];
  logic [63:0]       cap_data[$];
  int                done_cycles;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Lane k of global word n, straight from the pattern definitions
  function automatic logic [15:0] model_lane(input logic [1:0] mode, input logic [15:0] seed,
                                             input int n, input int k);
    case (mode)
      2'd1:    return seed;
      2'd2:    return (n % 2 == 1) ? ~seed : seed;
      default: return seed + 16'(k) + 16'(n * LANES);
    endcase
  endfunction

  function automatic logic [63:0] model_word(input logic [1:0] mode, input logic [15:0] seed,
                                             input int n);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < LANES; k++) w[(LANES-1-k)*16 +: 16] = model_lane(mode, seed, n, k);
    return w;
  endfunction

  // One complete run. stop_at: -1 none, 0 with start, N raise during N-th strobe.
  task automatic run_job(input logic [1:0] mode, input logic [15:0] seed, input int base,
                         input int count, input logic cont, input int stop_at,
                         input bit poke_start, input string tag);
    int eff, stop_eff, exp_w, exp_done, cyc, hold, last_rise, unstable, bound, p;
    bit prev_w, ended;
    logic [ADDR_W-1:0] a_hold;
    logic [63:0] d_hold;
    eff      = (count == 0) ? DEPTH : count;
    stop_eff = (stop_at == 0) ? 1 : stop_at;
    if (stop_at < 0) begin
      exp_w = eff; exp_done = 1;
    end else if (cont) begin
      exp_w = stop_eff; exp_done = (stop_eff - 1) / eff + 1;
    end else begin
      exp_w = (stop_eff < eff) ? stop_eff : eff; exp_done = 1;
    end
    cap_addr.delete(); cap_data.delete();
    done_cycles = 0; hold = 0; last_rise = 0; unstable = 0;
    prev_w = 1'b0; ended = 1'b0; a_hold = '0; d_hold = '0;
    bound = (exp_w + 2) * PERIOD + 20;

    @(negedge i_clk);
    bus.i_mode       = mode;
    bus.i_seed       = seed;
    bus.i_base_addr  = ADDR_W'(base);
    bus.i_count      = (ADDR_W+1)'(count);
    bus.i_continuous = cont;
    bus.i_stop       = (stop_at == 0);
    bus.i_start      = 1'b1;
    @(negedge i_clk);
    cyc = 1;
    bus.i_start = 1'b0;
    chk({tag, "_busy_after_start"}, 64'(bus.o_busy), 64'd1);

    while (!ended && cyc < bound) begin
      if (bus.o_done) done_cycles++;
      if (bus.o_wbit && !prev_w) begin
        if (cap_addr.size() == 0) begin
          chk({tag, "_setup_len"}, 64'(cyc), 64'(SETUP + 1));
          chk({tag, "_byteen"}, 64'(bus.o_byteen), 64'hFF);
        end else begin
          chk({tag, "_period"}, 64'(cyc - last_rise), 64'(PERIOD));
        end
        last_rise = cyc;
        cap_addr.push_back(bus.o_address);
        cap_data.push_back(bus.o_data);
        a_hold = bus.o_address; d_hold = bus.o_data; hold = 1;
        if (stop_at > 0 && cap_addr.size() == stop_at) bus.i_stop = 1'b1;
        if (poke_start && cap_addr.size() == 1) begin
          bus.i_start = 1'b1;
          bus.i_seed = ~seed; bus.i_base_addr = '0;
          bus.i_mode = mode + 2'd1; bus.i_count = (ADDR_W+1)'(1);
        end
      end else if (bus.o_wbit) begin
        hold++;
        if (bus.o_address !== a_hold || bus.o_data !== d_hold) unstable++;
      end else if (prev_w) begin
        chk({tag, "_hold_len"}, 64'(hold), 64'(HOLD));
      end
      prev_w = bus.o_wbit;
      if (!bus.o_busy) ended = 1'b1;
      @(negedge i_clk);
      cyc++;
      bus.i_start = 1'b0;
    end
    if (bus.o_done) done_cycles++;

    chk({tag, "_completed"}, 64'(ended), 64'd1);
    chk({tag, "_n_writes"}, 64'(cap_addr.size()), 64'(exp_w));
    chk({tag, "_done_cycles"}, 64'(done_cycles), 64'(exp_done));
    chk({tag, "_stable_in_strobe"}, 64'(unstable), 64'd0);
    chk({tag, "_wbit_idle"}, 64'(bus.o_wbit), 64'd0);
    for (int j = 0; j < cap_addr.size() && j < exp_w; j++) begin
      p = j % eff;
      chk({tag, "_addr"}, 64'(cap_addr[j]), 64'((base + p) % DEPTH));
      chk({tag, "_data"}, cap_data[j], model_word(mode, seed, j));
    end
    bus.i_stop = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
    int k;
    logic [1:0]  r_mode;
    logic [15:0] r_seed;
    int r_base, r_count, r_stop;
    logic r_cont;

    tbl[0] = '{2'd0, 16'h8000, 0,    3, 16'h8004, 16'h8007, 2};
    tbl[1] = '{2'd0, 16'h0000, 2046, 4, 16'h0004, 16'h0007, 1};
    tbl[2] = '{2'd0, 16'h7FFE, 10,   2, 16'h8002, 16'h8005, 11};
    tbl[3] = '{2'd1, 16'h1234, 5,    2, 16'h1234, 16'h1234, 6};
    tbl[4] = '{2'd2, 16'h00FF, 100,  3, 16'hFF00, 16'hFF00, 102};
    tbl[5] = '{2'd3, 16'h0010, 0,    2, 16'h0014, 16'h0017, 1};

    bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_continuous = 1'b0;
    bus.i_mode = 2'd0; bus.i_seed = '0; bus.i_base_addr = '0; bus.i_count = '0;

    repeat (3) @(negedge i_clk);
    chk("reset_data",    bus.o_data,           64'd0);
    chk("reset_address", 64'(bus.o_address),   64'd0);
    chk("reset_byteen",  64'(bus.o_byteen),    64'd0);
    chk("reset_wbit",    64'(bus.o_wbit),      64'd0);
    chk("reset_busy",    64'(bus.o_busy),      64'd0);
    chk("reset_done",    64'(bus.o_done),      64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < 6; i++) begin
      run_job(tbl[i].mode, tbl[i].seed, tbl[i].base, tbl[i].count, 1'b0, -1, 1'b0, "tbl");
      if (cap_data.size() >= 2) begin
        chk("tbl_w1_lane0", 64'(cap_data[1][63:48]), 64'(tbl[i].w1_l0));
        chk("tbl_w1_lane3", 64'(cap_data[1][15:0]),  64'(tbl[i].w1_l3));
        chk("tbl_last_addr", 64'(cap_addr[cap_addr.size()-1]), 64'(tbl[i].last_addr));
      end else begin
        chk("tbl_capture_size", 64'(cap_data.size()), 64'd2);
      end
      chk("tbl_busy_fell", 64'(bus.o_busy), 64'd0);
    end

    // Continuous checkerboard, stop raised during the 5th strobe
    run_job(2'd2, 16'h00FF, 300, 2, 1'b1, 5, 1'b0, "cont_stop");
    // Start while busy is ignored
    run_job(2'd0, 16'h1000, 50, 3, 1'b0, -1, 1'b1, "busy_start");
    // Start and stop together: exactly one word
    run_job(2'd0, 16'h2222, 9, 4, 1'b0, 0, 1'b0, "start_stop");
    // Count 0 means a full window; stop after three words
    run_job(2'd0, 16'hABCD, 2040, 0, 1'b0, 3, 1'b0, "count0");

    // Async reset during a strobe
    @(negedge i_clk);
    bus.i_mode = 2'd0; bus.i_seed = 16'h4000; bus.i_base_addr = ADDR_W'(7);
    bus.i_count = (ADDR_W+1)'(3); bus.i_continuous = 1'b0; bus.i_start = 1'b1;
    @(negedge i_clk);
    bus.i_start = 1'b0;
    k = 0;
    while (!bus.o_wbit && k < 20) begin
      @(negedge i_clk);
      k++;
    end
    chk("rst_reached_write", 64'(bus.o_wbit), 64'd1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_wbit",    64'(bus.o_wbit),    64'd0);
    chk("rst_busy",    64'(bus.o_busy),    64'd0);
    chk("rst_done",    64'(bus.o_done),    64'd0);
    chk("rst_data",    bus.o_data,         64'd0);
    chk("rst_address", 64'(bus.o_address), 64'd0);
    chk("rst_byteen",  64'(bus.o_byteen),  64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_job(2'd2, 16'h5A5A, 2047, 3, 1'b0, -1, 1'b0, "after_rst");

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      r_mode  = 2'($urandom_range(0, 3));
      r_seed  = 16'($urandom);
      r_base  = ($urandom_range(0, 1) == 0) ? DEPTH - 1 - int'($urandom_range(0, 3))
                                            : int'($urandom_range(0, DEPTH - 1));
      r_count = int'($urandom_range(1, 5));
      r_cont  = 1'($urandom_range(0, 1));
      if (r_cont) r_stop = int'($urandom_range(1, 7));
      else        r_stop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, r_count)) : -1;
      run_job(r_mode, r_seed, r_base, r_count, r_cont, r_stop, 1'b0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
